// File: rtl/k_fifo_pkg.sv
// Shared FIFO subsystem package: default sizes and pointer/depth helpers.
package k_fifo_pkg;

  localparam int DATA_SIZE_DEF = 8;
  localparam int ADDR_SIZE_DEF = 4;

  function automatic int depth_of(input int asz);
    return 1 << asz;
  endfunction

  function automatic int ptr_w(input int asz);
    return asz + 1;
  endfunction

endpackage

// File: rtl/k_dp_ndeep_ram_t2.sv
// Dual-port n-deep RAM with a registered read port on a single clock.
// Array contents are never reset; only the read register is.
module k_dp_ndeep_ram_t2
  import k_fifo_pkg::*;
#(
  parameter int data_size = DATA_SIZE_DEF,
  parameter int addr_size = ADDR_SIZE_DEF
) (
  input  logic                 wclk,
  input  logic                 wrst,
  input  logic                 wen,
  input  logic [addr_size-1:0] waddr,
  input  logic [data_size-1:0] wdata,
  input  logic                 ren,
  input  logic [addr_size-1:0] raddr,
  output logic [data_size-1:0] rdata
);

  localparam int DEPTH = depth_of(addr_size);

  logic [data_size-1:0] mem [DEPTH];

  always_ff @(posedge wclk) begin
    if (wen) mem[waddr] <= wdata;
  end

  always_ff @(posedge wclk) begin
    if (wrst)     rdata <= '0;
    else if (ren) rdata <= mem[raddr];
  end

endmodule

// File: rtl/k_sync_fifo_t2.sv
// Single-clock FIFO: pointers, occupancy, flags and registered read data.
// Sticky overflow/underflow built only when K_SYNC_FIFO_ERR_EN is defined.
module k_sync_fifo_t2
  import k_fifo_pkg::*;
#(
  parameter int data_size = DATA_SIZE_DEF,
  parameter int addr_size = ADDR_SIZE_DEF,
  parameter int af_level  = 1,
  parameter int ae_level  = 1
) (
  input  logic                 wclk,
  input  logic                 wrst,
  input  logic [data_size-1:0] wdata,
  input  logic                 wen,
  input  logic                 ren,
  output logic [data_size-1:0] rdata,
  output logic                 rvalid,
  output logic                 wfull,
  output logic                 rempty,
  output logic                 almost_full,
  output logic                 almost_empty,
  output logic [addr_size:0]   count,
  output logic                 overflow,
  output logic                 underflow
);

  localparam int DEPTH = depth_of(addr_size);
  localparam int PW    = ptr_w(addr_size);

  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic          wacc;
  logic          racc;

  // Flags come from the registered count only.
  assign wfull        = (count == PW'(DEPTH));
  assign rempty       = (count == '0);
  assign almost_full  = ((32'(count) + 32'(af_level)) >= 32'(DEPTH));
  assign almost_empty = (32'(count) <= 32'(ae_level));

  assign wacc = wen && !wfull;
  assign racc = ren && !rempty;

  always_ff @(posedge wclk) begin
    if (wrst) begin
      wptr   <= '0;
      rptr   <= '0;
      count  <= '0;
      rvalid <= 1'b0;
    end else begin
      if (wacc) wptr <= wptr + PW'(1);
      if (racc) rptr <= rptr + PW'(1);
      unique case ({wacc, racc})
        2'b10:   count <= count + PW'(1);
        2'b01:   count <= count - PW'(1);
        default: count <= count;
      endcase
      rvalid <= racc;
    end
  end

  k_dp_ndeep_ram_t2 #(
    .data_size (data_size),
    .addr_size (addr_size)
  ) u_ram (
    .wclk  (wclk),
    .wrst  (wrst),
    .wen   (wacc),
    .waddr (wptr[addr_size-1:0]),
    .wdata (wdata),
    .ren   (racc),
    .raddr (rptr[addr_size-1:0]),
    .rdata (rdata)
  );

`ifdef K_SYNC_FIFO_ERR_EN
  always_ff @(posedge wclk) begin
    if (wrst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wen && wfull)  overflow  <= 1'b1;
      if (ren && rempty) underflow <= 1'b1;
    end
  end
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_k_sync_fifo_t2.sv
// Directed self-checking bench for k_sync_fifo_t2 (depth 4).
// Error-flag expectations follow K_SYNC_FIFO_ERR_EN.
module tb_k_sync_fifo_t2;

  localparam int DW = 8;
  localparam int AW = 2;
`ifdef K_SYNC_FIFO_ERR_EN
  localparam bit ERR = 1'b1;
`else
  localparam bit ERR = 1'b0;
`endif

  logic          wclk = 1'b0;
  logic          wrst;
  logic [DW-1:0] wdata;
  logic          wen;
  logic          ren;
  logic [DW-1:0] rdata;
  logic          rvalid;
  logic          wfull;
  logic          rempty;
  logic          almost_full;
  logic          almost_empty;
  logic [AW:0]   count;
  logic          overflow;
  logic          underflow;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 wclk = ~wclk;

  k_sync_fifo_t2 #(
    .data_size (DW),
    .addr_size (AW),
    .af_level  (1),
    .ae_level  (1)
  ) dut (
    .wclk         (wclk),
    .wrst         (wrst),
    .wdata        (wdata),
    .wen          (wen),
    .ren          (ren),
    .rdata        (rdata),
    .rvalid       (rvalid),
    .wfull        (wfull),
    .rempty       (rempty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  task automatic step();
    @(posedge wclk);
    #1;
  endtask

  task automatic test_reset();
    wrst = 1'b1; wen = 1'b0; ren = 1'b0; wdata = '0;
    step();
    step();
    wrst = 1'b0;
    step();
    n_cmp++;
    if ({rempty, almost_empty, count, wfull, almost_full, rdata, rvalid,
         overflow, underflow} !== {1'b1, 1'b1, 3'd0, 1'b0, 1'b0, 8'h00,
         1'b0, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL reset: empty=%b aempty=%b count=%0d full=%b afull=%b rdata=%h rvalid=%b ovf=%b udf=%b required 1 1 0 0 0 00 0 0 0",
               rempty, almost_empty, count, wfull, almost_full, rdata,
               rvalid, overflow, underflow);
    end
  endtask

  task automatic test_fill_drain();
    logic [7:0] v [4];
    v[0] = 8'hA1; v[1] = 8'hB2; v[2] = 8'hC3; v[3] = 8'hD4;
    for (int i = 0; i < 4; i++) begin
      wen = 1'b1; wdata = v[i];
      step();
      n_cmp++;
      if ({count, almost_full, wfull, almost_empty} !==
          {3'(i + 1), (i >= 2), (i == 3), (i == 0)}) begin
        n_bad++;
        $display("FAIL fill[%0d]: count=%0d af=%b full=%b ae=%b required %0d %b %b %b",
                 i, count, almost_full, wfull, almost_empty, i + 1,
                 (i >= 2), (i == 3), (i == 0));
      end
    end
    wen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ren = 1'b1;
      step();
      n_cmp++;
      if ({rvalid, rdata, count} !== {1'b1, v[i], 3'(3 - i)}) begin
        n_bad++;
        $display("FAIL drain[%0d]: rvalid=%b rdata=%h count=%0d required 1 %h %0d",
                 i, rvalid, rdata, count, v[i], 3 - i);
      end
    end
    ren = 1'b0;
    step();
    n_cmp++;
    if ({rvalid, rempty, rdata} !== {1'b0, 1'b1, 8'hD4}) begin
      n_bad++;
      $display("FAIL drained: rvalid=%b empty=%b rdata=%h required 0 1 d4",
               rvalid, rempty, rdata);
    end
  endtask

  task automatic test_full_rw();
    logic [7:0] v [4];
    v[0] = 8'h11; v[1] = 8'h22; v[2] = 8'h33; v[3] = 8'h44;
    for (int i = 0; i < 4; i++) begin
      wen = 1'b1; wdata = v[i];
      step();
    end
    n_cmp++;
    if ({wfull, overflow} !== {1'b1, 1'b0}) begin
      n_bad++;
      $display("FAIL full_pre: full=%b ovf=%b required 1 0", wfull, overflow);
    end
    wen = 1'b1; ren = 1'b1; wdata = 8'hEE;
    step();
    wen = 1'b0; ren = 1'b0;
    n_cmp++;
    if ({rvalid, rdata, count, wfull, overflow} !==
        {1'b1, 8'h11, 3'd3, 1'b0, ERR}) begin
      n_bad++;
      $display("FAIL full_rw: rvalid=%b rdata=%h count=%0d full=%b ovf=%b required 1 11 3 0 %b",
               rvalid, rdata, count, wfull, overflow, ERR);
    end
    for (int i = 1; i < 4; i++) begin
      ren = 1'b1;
      step();
      n_cmp++;
      if ({rvalid, rdata} !== {1'b1, v[i]}) begin
        n_bad++;
        $display("FAIL full_tail[%0d]: rvalid=%b rdata=%h required 1 %h",
                 i, rvalid, rdata, v[i]);
      end
    end
    ren = 1'b0;
    step();
    n_cmp++;
    if ({rempty, rvalid, count} !== {1'b1, 1'b0, 3'd0}) begin
      n_bad++;
      $display("FAIL full_end: empty=%b rvalid=%b count=%0d required 1 0 0",
               rempty, rvalid, count);
    end
  endtask

  task automatic test_empty_rw();
    wen = 1'b1; ren = 1'b1; wdata = 8'h55;
    step();
    wen = 1'b0;
    n_cmp++;
    if ({rvalid, count, underflow, overflow} !== {1'b0, 3'd1, ERR, ERR}) begin
      n_bad++;
      $display("FAIL empty_rw: rvalid=%b count=%0d udf=%b ovf=%b required 0 1 %b %b",
               rvalid, count, underflow, overflow, ERR, ERR);
    end
    step();
    ren = 1'b0;
    n_cmp++;
    if ({rvalid, rdata, count} !== {1'b1, 8'h55, 3'd0}) begin
      n_bad++;
      $display("FAIL empty_next: rvalid=%b rdata=%h count=%0d required 1 55 0",
               rvalid, rdata, count);
    end
    step();
    n_cmp++;
    if ({rvalid, rdata} !== {1'b0, 8'h55}) begin
      n_bad++;
      $display("FAIL rdata_hold: rvalid=%b rdata=%h required 0 55",
               rvalid, rdata);
    end
  endtask

  task automatic test_wrap();
    wen = 1'b1;
    wdata = 8'h60; step();
    wdata = 8'h61; step();
    for (int i = 0; i < 10; i++) begin
      wen = 1'b1; ren = 1'b1; wdata = 8'(8'h62 + i);
      step();
      n_cmp++;
      if ({rvalid, rdata, count} !== {1'b1, 8'(8'h60 + i), 3'd2}) begin
        n_bad++;
        $display("FAIL wrap[%0d]: rvalid=%b rdata=%h count=%0d required 1 %h 2",
                 i, rvalid, rdata, count, 8'(8'h60 + i));
      end
    end
    wen = 1'b0; ren = 1'b1;
    step();
    n_cmp++;
    if (rdata !== 8'h6A) begin
      n_bad++;
      $display("FAIL wrap_tail0: rdata=%h required 6a", rdata);
    end
    step();
    ren = 1'b0;
    n_cmp++;
    if ({rdata, rempty} !== {8'h6B, 1'b1}) begin
      n_bad++;
      $display("FAIL wrap_tail1: rdata=%h empty=%b required 6b 1",
               rdata, rempty);
    end
  endtask

  task automatic test_reset_mid();
    wen = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wdata = 8'(8'h70 + i);
      step();
    end
    wen = 1'b0;
    n_cmp++;
    if (count !== 3'd3) begin
      n_bad++;
      $display("FAIL mid_pre: count=%0d required 3", count);
    end
    ren = 1'b1; wrst = 1'b1;
    step();
    ren = 1'b0; wrst = 1'b0;
    n_cmp++;
    if ({count, rempty, almost_empty, rvalid, rdata, overflow, underflow} !==
        {3'd0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL mid_reset: count=%0d empty=%b ae=%b rvalid=%b rdata=%h ovf=%b udf=%b required 0 1 1 0 00 0 0",
               count, rempty, almost_empty, rvalid, rdata, overflow,
               underflow);
    end
    step();
    n_cmp++;
    if ({count, rvalid} !== {3'd0, 1'b0}) begin
      n_bad++;
      $display("FAIL mid_after: count=%0d rvalid=%b required 0 0",
               count, rvalid);
    end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_full_rw();
    test_empty_rw();
    test_wrap();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
